// File: rtl/park_pkg.sv
// ---------------------------------------------------------------------------
// park_pkg
// Shared constants and types for the parking-lot occupancy logic.
//   NUM_SPOTS        : number of managed spots (bit i of occupancy = spot i)
//   IDX_W            : width of a spot code (encoder output, exit index)
//   SPOT_W           : bits needed to address a real spot
//   FULL_CODE        : encoder code meaning "no free spot"
//   GATE_OPEN_CYCLES : cycles the entry gate stays open after a grant
//   TIMER_W          : width of the gate countdown timer
//   state_e          : allocator FSM states
//   popcount()       : number of taken spots in an occupancy vector
// ---------------------------------------------------------------------------
package park_pkg;

    localparam int NUM_SPOTS        = 4;
    localparam int IDX_W            = 3;
    localparam int SPOT_W           = $clog2(NUM_SPOTS);
    localparam logic [IDX_W-1:0] FULL_CODE = 3'b101;
    localparam int GATE_OPEN_CYCLES = 8;
    localparam int TIMER_W          = $clog2(GATE_OPEN_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    // Count of set bits; result always fits IDX_W since NUM_SPOTS < 2**IDX_W.
    function automatic logic [IDX_W-1:0] popcount(input logic [NUM_SPOTS-1:0] vec);
        logic [IDX_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            total = total + IDX_W'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/spot_allocator_if.sv
// ---------------------------------------------------------------------------
// spot_allocator_if
// Bundles the request/response signals of the spot allocator.
//   master : the lot environment (entry/exit sensors, first-free encoder)
//            drives entry_req, exit_req, exit_idx, loc_code and observes the rest
//   slave  : the allocator itself
// Signals:
//   entry_req, exit_req, exit_idx, loc_code  -> into the allocator
//   occupancy, entry_grant, entry_deny, entry_idx, exit_ack, exit_err,
//   gate_open, full, count                   <- out of the allocator
// ---------------------------------------------------------------------------
interface spot_allocator_if;
    import park_pkg::*;

    logic                 entry_req;
    logic                 exit_req;
    logic [IDX_W-1:0]     exit_idx;
    logic [IDX_W-1:0]     loc_code;
    logic [NUM_SPOTS-1:0] occupancy;
    logic                 entry_grant;
    logic                 entry_deny;
    logic [IDX_W-1:0]     entry_idx;
    logic                 exit_ack;
    logic                 exit_err;
    logic                 gate_open;
    logic                 full;
    logic [IDX_W-1:0]     count;

    modport master (
        output entry_req, exit_req, exit_idx, loc_code,
        input  occupancy, entry_grant, entry_deny, entry_idx,
               exit_ack, exit_err, gate_open, full, count
    );

    modport slave (
        input  entry_req, exit_req, exit_idx, loc_code,
        output occupancy, entry_grant, entry_deny, entry_idx,
               exit_ack, exit_err, gate_open, full, count
    );

endinterface

// File: rtl/first_free_encoder.sv
// ---------------------------------------------------------------------------
// first_free_encoder
// Combinational first-free-spot encoder that sits in front of the allocator:
// reports the lowest-numbered free spot, or FULL_CODE when every spot is taken.
//   occ_i  : occupancy vector (1 = taken)
//   code_o : lowest free spot index, or FULL_CODE
// ---------------------------------------------------------------------------
module first_free_encoder
    import park_pkg::*;
(
    input  logic [NUM_SPOTS-1:0] occ_i,
    output logic [IDX_W-1:0]     code_o
);

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        code_o = FULL_CODE;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occ_i[i]) begin
                code_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spot_decoder.sv
// ---------------------------------------------------------------------------
// spot_decoder
// Turns a spot code into a one-hot spot mask. Codes that do not name a real
// spot (>= NUM_SPOTS, including FULL_CODE) produce an all-zero mask, so the
// caller can use "mask is non-zero" as "code is a real spot".
//   code_i   : IDX_W-bit spot code
//   onehot_o : NUM_SPOTS-bit mask, bit code_i set
// ---------------------------------------------------------------------------
module spot_decoder
    import park_pkg::*;
(
    input  logic [IDX_W-1:0]     code_i,
    output logic [NUM_SPOTS-1:0] onehot_o
);

    // Plain decode with range guard for out-of-lot codes.
    always_comb begin
        onehot_o = '0;
        if (code_i < IDX_W'(NUM_SPOTS)) begin
            onehot_o[code_i[SPOT_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/spot_allocator.sv
// ---------------------------------------------------------------------------
// spot_allocator
// Sequential occupancy manager for the parking lot. Owns the occupancy vector
// that feeds the first-free encoder, allocates the returned spot on car entry,
// releases spots on car exit, runs the entry-gate timer and reports full/count.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spot_allocator_if.slave
//           in : entry_req, exit_req, exit_idx, loc_code
//           out: occupancy, entry_grant, entry_deny, entry_idx, exit_ack,
//                exit_err, gate_open, full, count (all registered)
// ---------------------------------------------------------------------------
module spot_allocator
    import park_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    spot_allocator_if.slave bus
);

    state_e               state_q,     state_d;
    logic [TIMER_W-1:0]   timer_q,     timer_d;
    logic                 pend_q,      pend_d;
    logic [NUM_SPOTS-1:0] occ_q,       occ_d;
    logic [IDX_W-1:0]     entry_idx_q, entry_idx_d;
    logic [IDX_W-1:0]     count_q,     count_d;
    logic                 full_q,      full_d;
    logic                 grant_q,     grant_d;
    logic                 deny_q,      deny_d;
    logic                 ack_q,       ack_d;
    logic                 err_q,       err_d;
    logic                 gate_q,      gate_d;

    logic [NUM_SPOTS-1:0] alloc_oh;
    logic [NUM_SPOTS-1:0] release_oh;
    logic                 alloc_ok;
    logic                 exit_valid;
    logic                 entry_want;

    // Spot code from the encoder -> bit to set on a grant.
    spot_decoder u_alloc_dec (
        .code_i   (bus.loc_code),
        .onehot_o (alloc_oh)
    );

    // Exit index -> bit to clear on a release.
    spot_decoder u_release_dec (
        .code_i   (bus.exit_idx),
        .onehot_o (release_oh)
    );

    // Codes 4..7 decode to zero, so FULL_CODE and the unused codes all deny.
    assign alloc_ok   = |alloc_oh;
    assign exit_valid = |(release_oh & occ_q);
    assign entry_want = bus.entry_req | pend_q;

    // State and output registers; reset also aborts a gate in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            occ_q       <= '0;
            entry_idx_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            occ_q       <= occ_d;
            entry_idx_q <= entry_idx_d;
            count_q     <= count_d;
            full_q      <= full_d;
            grant_q     <= grant_d;
            deny_q      <= deny_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            gate_q      <= gate_d;
        end
    end

    // Next-state logic. Exits are served in any state. An entry is served only
    // in IDLE and only when no exit is pending this cycle; otherwise it is
    // parked in the one-deep pend flag so it sees the post-exit occupancy.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        occ_d       = occ_q;
        entry_idx_d = entry_idx_q;
        grant_d     = 1'b0;
        deny_d      = 1'b0;
        ack_d       = 1'b0;
        err_d       = 1'b0;

        if (bus.exit_req) begin
            if (exit_valid) begin
                occ_d = occ_q & ~release_oh;
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (entry_want) begin
                    if (bus.exit_req) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                        if (alloc_ok) begin
                            occ_d       = occ_q | alloc_oh;
                            grant_d     = 1'b1;
                            entry_idx_d = bus.loc_code;
                            timer_d     = TIMER_W'(GATE_OPEN_CYCLES - 1);
                            state_d     = GATE;
                        end else begin
                            deny_d = 1'b1;
                        end
                    end
                end
            end
            GATE: begin
                // Further pulses while already pending are dropped.
                if (bus.entry_req) begin
                    pend_d = 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status follows the occupancy being written this cycle.
        count_d = popcount(occ_d);
        full_d  = &occ_d;
        gate_d  = (state_d == GATE);
    end

    assign bus.occupancy   = occ_q;
    assign bus.entry_grant = grant_q;
    assign bus.entry_deny  = deny_q;
    assign bus.entry_idx   = entry_idx_q;
    assign bus.exit_ack    = ack_q;
    assign bus.exit_err    = err_q;
    assign bus.gate_open   = gate_q;
    assign bus.full        = full_q;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_spot_allocator.sv
// ---------------------------------------------------------------------------
// tb_spot_allocator
// Closed-loop bench: spot_allocator with a first_free_encoder on its
// occupancy output, a behavioural lot model, a per-cycle compare process and
// directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_spot_allocator;
    import park_pkg::*;

    logic clk;
    logic rst_n;

    spot_allocator_if bus();

    logic [NUM_SPOTS-1:0] encOcc;
    logic [IDX_W-1:0]     encCode;

    int numChecks = 0;
    int numFails  = 0;

    // Behavioural model: list of taken spots, gate cycles remaining, a
    // single pending-entry flag, and the pulses expected after each edge.
    bit mTaken [NUM_SPOTS];
    int mIdx;
    bit mGrant, mDeny, mAck, mErr;
    int gateLeft;
    bit mPend;
    int freeSpot;
    int exitSpot;

    spot_allocator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    first_free_encoder uEnc (
        .occ_i  (encOcc),
        .code_o (encCode)
    );

    assign encOcc       = bus.occupancy;
    assign bus.loc_code = encCode;

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelOcc();
        int v = 0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (mTaken[i]) v += (1 << i);
        end
        return v;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (mTaken[i]) c++;
        end
        return c;
    endfunction

    // Model update: what the lot must look like after each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPOTS; i++) mTaken[i] = 1'b0;
            mIdx = 0; mGrant = 0; mDeny = 0; mAck = 0; mErr = 0;
            gateLeft = 0; mPend = 0;
        end else begin
            mGrant = 0; mDeny = 0; mAck = 0; mErr = 0;
            // Find the first free spot before this edge's exit changes anything.
            freeSpot = -1;
            for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
                if (!mTaken[i]) freeSpot = i;
            end
            if (bus.exit_req) begin
                exitSpot = int'(bus.exit_idx);
                if (exitSpot < NUM_SPOTS && mTaken[exitSpot]) begin
                    mTaken[exitSpot] = 1'b0;
                    mAck = 1;
                end else begin
                    mErr = 1;
                end
            end
            if (gateLeft > 0) begin
                if (bus.entry_req) mPend = 1;
                gateLeft--;
            end else if (bus.entry_req || mPend) begin
                if (bus.exit_req) begin
                    mPend = 1;
                end else begin
                    mPend = 0;
                    if (freeSpot >= 0) begin
                        mTaken[freeSpot] = 1'b1;
                        mIdx     = freeSpot;
                        mGrant   = 1;
                        gateLeft = GATE_OPEN_CYCLES;
                    end else begin
                        mDeny = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_occupancy", int'(bus.occupancy), modelOcc());
            checkOutput("cyc_count", int'(bus.count), modelCount());
            checkOutput("cyc_full", int'(bus.full), int'(modelCount() == NUM_SPOTS));
            checkOutput("cyc_grant", int'(bus.entry_grant), int'(mGrant));
            checkOutput("cyc_deny", int'(bus.entry_deny), int'(mDeny));
            checkOutput("cyc_entry_idx", int'(bus.entry_idx), mIdx);
            checkOutput("cyc_ack", int'(bus.exit_ack), int'(mAck));
            checkOutput("cyc_err", int'(bus.exit_err), int'(mErr));
            checkOutput("cyc_gate", int'(bus.gate_open), int'(gateLeft > 0));
        end
    end

    // One-cycle request pulse; returns at the negedge after the serving edge.
    task automatic applyStimulus(input bit entry, input bit exitReq, input int idx);
        @(negedge clk);
        bus.entry_req = entry;
        bus.exit_req  = exitReq;
        bus.exit_idx  = IDX_W'(idx);
        @(negedge clk);
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_idx  = '0;
    endtask

    // Bounded wait for the gate to drop; a timeout counts as a failure.
    task automatic waitGateClosed();
        int waited = 0;
        while (bus.gate_open && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("gate_close_timeout", int'(bus.gate_open), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_idx  = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_occupancy", int'(bus.occupancy), 0);
        checkOutput("rst_count", int'(bus.count), 0);
        checkOutput("rst_full", int'(bus.full), 0);
        checkOutput("rst_gate", int'(bus.gate_open), 0);
        checkOutput("rst_entry_idx", int'(bus.entry_idx), 0);
        rst_n = 1'b1;

        $display("[TB] four entries from empty");
        for (int k = 0; k < NUM_SPOTS; k++) begin
            applyStimulus(1'b1, 1'b0, 0);
            checkOutput("fill_grant", int'(bus.entry_grant), 1);
            checkOutput("fill_idx", int'(bus.entry_idx), k);
            checkOutput("fill_gate", int'(bus.gate_open), 1);
            waitGateClosed();
        end
        checkOutput("fill_occupancy", int'(bus.occupancy), 4'b1111);
        checkOutput("fill_count", int'(bus.count), 4);
        checkOutput("fill_full", int'(bus.full), 1);

        $display("[TB] entry on full lot");
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("deny_pulse", int'(bus.entry_deny), 1);
        checkOutput("deny_grant", int'(bus.entry_grant), 0);
        checkOutput("deny_occupancy", int'(bus.occupancy), 4'b1111);

        $display("[TB] exit spot 2 then refill");
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("exit2_ack", int'(bus.exit_ack), 1);
        checkOutput("exit2_occupancy", int'(bus.occupancy), 4'b1011);
        checkOutput("exit2_count", int'(bus.count), 3);
        checkOutput("exit2_full", int'(bus.full), 0);
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("refill_idx", int'(bus.entry_idx), 2);
        checkOutput("refill_occupancy", int'(bus.occupancy), 4'b1111);
        waitGateClosed();

        $display("[TB] simultaneous entry and exit of spot 0");
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("simul_ack", int'(bus.exit_ack), 1);
        checkOutput("simul_no_grant", int'(bus.entry_grant), 0);
        checkOutput("simul_occupancy", int'(bus.occupancy), 4'b1110);
        @(negedge clk);
        checkOutput("simul_grant", int'(bus.entry_grant), 1);
        checkOutput("simul_idx", int'(bus.entry_idx), 0);
        checkOutput("simul_occ_after", int'(bus.occupancy), 4'b1111);
        waitGateClosed();

        $display("[TB] invalid exits");
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("exit6_err", int'(bus.exit_err), 1);
        checkOutput("exit6_occupancy", int'(bus.occupancy), 4'b1111);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("exit4_err", int'(bus.exit_err), 1);
        for (int s = 1; s < NUM_SPOTS; s++) begin
            applyStimulus(1'b0, 1'b1, s);
            checkOutput("drain_ack", int'(bus.exit_ack), 1);
        end
        checkOutput("drain_occupancy", int'(bus.occupancy), 4'b0001);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("free1_err", int'(bus.exit_err), 1);
        checkOutput("free1_ack", int'(bus.exit_ack), 0);
        checkOutput("free1_occupancy", int'(bus.occupancy), 4'b0001);

        $display("[TB] entries during gate");
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("gate_first_idx", int'(bus.entry_idx), 1);
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("gate_pend_no_grant", int'(bus.entry_grant), 0);
        applyStimulus(1'b1, 1'b0, 0);
        waitGateClosed();
        @(negedge clk);
        checkOutput("pend_grant", int'(bus.entry_grant), 1);
        checkOutput("pend_idx", int'(bus.entry_idx), 2);
        waitGateClosed();
        repeat (3) @(negedge clk);
        checkOutput("dropped_occupancy", int'(bus.occupancy), 4'b0111);
        checkOutput("dropped_count", int'(bus.count), 3);

        $display("[TB] reset in the middle of a gate");
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("pre_rst_idx", int'(bus.entry_idx), 3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_gate", int'(bus.gate_open), 0);
        checkOutput("midrst_occupancy", int'(bus.occupancy), 0);
        checkOutput("midrst_full", int'(bus.full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("post_rst_grant", int'(bus.entry_grant), 1);
        checkOutput("post_rst_idx", int'(bus.entry_idx), 0);
        waitGateClosed();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
